// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative signed/unsigned multiply-divide with fixed WIDTH+3 cycle latency and pipeline stall
module ex_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int RD_W  = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic [RD_W-1:0]  rd_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [RD_W-1:0]  rd_o,
  output logic             div0_o
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t r_state, w_state_n;
  logic [CW-1:0] r_cnt;
  logic [2*WIDTH-1:0] r_acc, w_mstep, w_dstep, w_prod;
  logic [WIDTH-1:0] r_b, r_d1, r_lo, r_hi, w_a_mag, w_b_mag, w_rsub, w_q, w_r, w_fix_lo, w_fix_hi;
  logic [WIDTH:0] w_madd, w_rsh;
  logic [RD_W-1:0] r_rd_c, r_rd;
  logic r_div, r_neg_q, r_neg_r, r_div0;
  logic w_accept, w_a_neg, w_b_neg, w_ge, w_div0;
  assign w_accept = (r_state == IDLE) & start_i & ~flush_i;
  assign w_a_neg  = ~op_i[0] & data1_i[WIDTH-1];
  assign w_b_neg  = ~op_i[0] & data2_i[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -data1_i : data1_i;
  assign w_b_mag  = w_b_neg ? -data2_i : data2_i;
  // Multiply: low half starts as the multiplier and is shifted out while the product fills in from the top
  assign w_madd   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mstep  = {w_madd, r_acc[WIDTH-1:1]};
  // Divide: upper half is the partial remainder, lower half shifts dividend out and quotient in
  assign w_rsh    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_ge     = w_rsh >= {1'b0, r_b};
  assign w_rsub   = w_rsh[WIDTH-1:0] - r_b;
  assign w_dstep  = {w_ge ? w_rsub : w_rsh[WIDTH-1:0], r_acc[WIDTH-2:0], w_ge};
  assign w_prod   = r_neg_q ? -r_acc : r_acc;
  assign w_q      = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_r      = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  assign w_div0   = r_div & ~|r_b;
  assign w_fix_lo = w_div0 ? '1 : r_div ? w_q : w_prod[WIDTH-1:0];
  assign w_fix_hi = w_div0 ? r_d1 : r_div ? w_r : w_prod[2*WIDTH-1:WIDTH];
  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      IDLE: w_state_n = w_accept ? RUN : IDLE;
      RUN:  w_state_n = flush_i ? IDLE : (r_cnt == CW'(WIDTH-1)) ? FIX : RUN;
      FIX:  w_state_n = flush_i ? IDLE : DONE;
      DONE: w_state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_rd    <= '0;
      r_div0  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      if (w_accept) begin
        r_acc   <= {{WIDTH{1'b0}}, w_a_mag};
        r_b     <= w_b_mag;
        r_d1    <= data1_i;
        r_rd_c  <= rd_i;
        r_div   <= op_i[1];
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
        r_cnt   <= '0;
      end
      if (r_state == RUN) begin
        r_acc <= r_div ? w_dstep : w_mstep;
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == FIX && !flush_i) begin
        r_lo   <= w_fix_lo;
        r_hi   <= w_fix_hi;
        r_rd   <= r_rd_c;
        r_div0 <= w_div0;
      end
    end
  end
  assign stall_o = w_accept | (r_state == RUN) | (r_state == FIX);
  assign done_o  = r_state == DONE;
  assign lo_o    = r_lo;
  assign hi_o    = r_hi;
  assign rd_o    = r_rd;
  assign div0_o  = r_div0;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: table vectors, random ops against an arithmetic model, flush and reset sequences
module tb_ex_muldiv_unit;
  logic clk_i = 1'b0;
  logic rst_i, start_i, flush_i;
  logic [1:0] op_i;
  logic [31:0] data1_i, data2_i;
  logic [4:0] rd_i;
  logic stall_o, done_o, div0_o;
  logic [31:0] lo_o, hi_o;
  logic [4:0] rd_o;
  int n_chk = 0, n_err = 0;
  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic [31:0] lo, hi;
    logic        d0;
  } vec_t;
  vec_t tbl[$];
  ex_muldiv_unit dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .data1_i(data1_i), .data2_i(data2_i), .rd_i(rd_i), .flush_i(flush_i),
    .stall_o(stall_o), .done_o(done_o), .lo_o(lo_o), .hi_o(hi_o),
    .rd_o(rd_o), .div0_o(div0_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] lo, output logic [31:0] hi, output logic d0);
    longint sp, sq, sr;
    logic [63:0] up;
    d0 = 1'b0;
    if (op == 2'b00) begin
      sp = longint'($signed(a)) * longint'($signed(b));
      up = sp;
      {hi, lo} = up;
    end else if (op == 2'b01) begin
      up = 64'(a) * 64'(b);
      {hi, lo} = up;
    end else if (b == 0) begin
      lo = '1; hi = a; d0 = 1'b1;
    end else if (op == 2'b10) begin
      sq = longint'($signed(a)) / longint'($signed(b));
      sr = longint'($signed(a)) % longint'($signed(b));
      lo = sq[31:0]; hi = sr[31:0];
    end else begin
      lo = a / b; hi = a % b;
    end
  endfunction
  // Called at posedge+1 of cycle 0; returns at posedge+1 of cycle 35 with start_i still high
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        output logic [31:0] lo, output logic [31:0] hi, output logic [4:0] rdo, output logic d0);
    int bad = 0, dn = 0, dk = -1;
    op_i = op; data1_i = a; data2_i = b; rd_i = rd; start_i = 1'b1;
    lo = 'x; hi = 'x; rdo = 'x; d0 = 1'bx;
    for (int k = 0; k < 35; k++) begin
      @(negedge clk_i);
      if (stall_o !== (k <= 33)) bad++;
      if (done_o === 1'b1) begin
        dn++;
        if (dk < 0) dk = k;
      end
      if (k == 34) begin
        lo = lo_o; hi = hi_o; rdo = rd_o; d0 = div0_o;
      end
      @(posedge clk_i);
    end
    #1;
    chk("stall_pattern", 64'(bad), 64'd0);
    chk("done_cycle", 64'(dk), 64'd34);
    chk("done_count", 64'(dn), 64'd1);
  endtask
  initial begin
    logic [31:0] lo, hi, elo, ehi, plo, phi;
    logic [4:0] rdo, prd, erd;
    logic d0, ed0, pd0;
    int dn;
    tbl.push_back('{2'b00, 32'd7, 32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0});
    tbl.push_back('{2'b11, 32'd100, 32'd7, 5'd9, 32'd14, 32'd2, 1'b0});
    tbl.push_back('{2'b10, 32'hFFFFFFF9, 32'd2, 5'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0});
    tbl.push_back('{2'b10, 32'h80000000, 32'hFFFFFFFF, 5'd3, 32'h80000000, 32'd0, 1'b0});
    tbl.push_back('{2'b10, 32'd5, 32'd0, 5'd4, 32'hFFFFFFFF, 32'd5, 1'b1});
    tbl.push_back('{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 32'h00000001, 32'hFFFFFFFE, 1'b0});
    tbl.push_back('{2'b11, 32'hFFFFFFFF, 32'd0, 5'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1});
    tbl.push_back('{2'b10, 32'd7, 32'hFFFFFFFE, 5'd7, 32'hFFFFFFFD, 32'd1, 1'b0});
    tbl.push_back('{2'b00, 32'h80000000, 32'h80000000, 5'd31, 32'd0, 32'h40000000, 1'b0});
    tbl.push_back('{2'b11, 32'd3, 32'd10, 5'd8, 32'd0, 32'd3, 1'b0});
    rst_i = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = '0; data1_i = '0; data2_i = '0; rd_i = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("reset_lo", 64'(lo_o), 64'd0);
    chk("reset_hi", 64'(hi_o), 64'd0);
    chk("reset_rd", 64'(rd_o), 64'd0);
    chk("reset_div0", 64'(div0_o), 64'd0);
    chk("reset_done", 64'(done_o), 64'd0);
    chk("reset_stall", 64'(stall_o), 64'd0);
    @(posedge clk_i);
    #1;
    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rd, lo, hi, rdo, d0);
      chk($sformatf("tbl%0d_lo", i), 64'(lo), 64'(tbl[i].lo));
      chk($sformatf("tbl%0d_hi", i), 64'(hi), 64'(tbl[i].hi));
      chk($sformatf("tbl%0d_rd", i), 64'(rdo), 64'(tbl[i].rd));
      chk($sformatf("tbl%0d_div0", i), 64'(d0), 64'(tbl[i].d0));
    end
    for (int i = 0; i < 24; i++) begin
      logic [1:0] op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      erd = 5'($urandom);
      model(op, a, b, elo, ehi, ed0);
      run_op(op, a, b, erd, lo, hi, rdo, d0);
      chk($sformatf("rnd%0d_lo op%0d %h,%h", i, op, a, b), 64'(lo), 64'(elo));
      chk($sformatf("rnd%0d_hi op%0d %h,%h", i, op, a, b), 64'(hi), 64'(ehi));
      chk($sformatf("rnd%0d_rd", i), 64'(rdo), 64'(erd));
      chk($sformatf("rnd%0d_div0", i), 64'(d0), 64'(ed0));
    end
    start_i = 1'b0;
    plo = lo; phi = hi; prd = rdo; pd0 = d0;
    @(posedge clk_i);
    #1 op_i = 2'b00; data1_i = 32'd3; data2_i = 32'd4; rd_i = 5'd12; start_i = 1'b1;
    repeat (10) @(posedge clk_i);
    #1 flush_i = 1'b1; start_i = 1'b0;
    @(posedge clk_i);
    #1 flush_i = 1'b0;
    @(negedge clk_i);
    chk("flush_stall_c11", 64'(stall_o), 64'd0);
    dn = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      if (done_o === 1'b1) dn++;
    end
    chk("flush_no_done", 64'(dn), 64'd0);
    chk("flush_lo_kept", 64'(lo_o), 64'(plo));
    chk("flush_hi_kept", 64'(hi_o), 64'(phi));
    chk("flush_rd_kept", 64'(rd_o), 64'(prd));
    chk("flush_div0_kept", 64'(div0_o), 64'(pd0));
    @(posedge clk_i);
    #1 start_i = 1'b1; flush_i = 1'b1;
    #1 chk("idle_flush_stall", 64'(stall_o), 64'd0);
    @(posedge clk_i);
    #1 start_i = 1'b0; flush_i = 1'b0;
    #1 chk("idle_flush_not_taken", 64'(stall_o), 64'd0);
    @(posedge clk_i);
    #1 op_i = 2'b11; data1_i = 32'd100; data2_i = 32'd7; rd_i = 5'd3; start_i = 1'b1;
    repeat (20) @(posedge clk_i);
    #1 rst_i = 1'b1; start_i = 1'b0;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_mid_lo", 64'(lo_o), 64'd0);
    chk("rst_mid_hi", 64'(hi_o), 64'd0);
    chk("rst_mid_rd", 64'(rd_o), 64'd0);
    chk("rst_mid_div0", 64'(div0_o), 64'd0);
    chk("rst_mid_done", 64'(done_o), 64'd0);
    chk("rst_mid_stall", 64'(stall_o), 64'd0);
    dn = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      if (done_o === 1'b1) dn++;
    end
    chk("rst_no_done", 64'(dn), 64'd0);
    @(posedge clk_i);
    #1;
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, 5'd17, lo, hi, rdo, d0);
    chk("post_rst_lo", 64'(lo), 64'hFFFFFFFD);
    chk("post_rst_hi", 64'(hi), 64'hFFFFFFFF);
    chk("post_rst_rd", 64'(rdo), 64'd17);
    chk("post_rst_div0", 64'(d0), 64'd0);
    start_i = 1'b0;
    repeat (2) @(posedge clk_i);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
